// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch controller state encoding, fault codes and word width.
package cpu_defs_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } fetch_state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_TIMEOUT  = 2'b10
    } fault_code_t;

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Saturating up-counter with clear and enable; tc flags that the count has reached TIMEOUT-1.
module fetch_timeout_cnt #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch-side controller: one word read per fetch request over req/ack, IR write strobe,
// misalignment and timeout fault reporting. All outputs come straight from flops.
module inst_fetch_ctrl
    import cpu_defs_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch,
    input  logic [WORD_W-1:0] pc,
    input  logic              flush,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              ir_wr,
    output logic [WORD_W-1:0] instr,
    output logic              busy,
    output logic              fault,
    output logic [1:0]        fault_code
);

    fetch_state_t state;
    fetch_state_t next_state;
    logic         accept;
    logic         aligned;
    logic         cnt_en;
    logic         timed_out;

    assign aligned = (pc[1:0] == 2'b00);
    assign accept  = (state == IDLE) && fetch && !flush;
    // Counter is zero during REQ and counts every cycle a request is outstanding.
    assign cnt_en  = (state == REQ) || (state == WAIT);

    fetch_timeout_cnt #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!cnt_en),
        .en    (cnt_en),
        .tc    (timed_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (fetch) next_state = aligned ? REQ : ERR;
            REQ:  next_state = WAIT;
            WAIT: begin
                if (mem_ack) begin
                    next_state = DONE;
                end else if (timed_out) begin
                    next_state = ERR;
                end
            end
            DONE:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) next_state = IDLE;
    end

    // Outputs are decoded from next_state into flops so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            ir_wr      <= 1'b0;
            instr      <= '0;
            busy       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
        end else begin
            mem_req <= (next_state == REQ) || (next_state == WAIT);
            busy    <= (next_state != IDLE);
            ir_wr   <= (next_state == DONE);
            fault   <= (next_state == ERR);

            if (accept && aligned) begin
                mem_addr   <= pc;
                fault_code <= FC_NONE;
            end
            if (accept && !aligned) begin
                fault_code <= FC_MISALIGN;
            end
            // Ack wins over a same-cycle timeout; flush discards both.
            if ((state == WAIT) && !flush) begin
                if (mem_ack) begin
                    instr <= mem_rdata;
                end else if (timed_out) begin
                    fault_code <= FC_TIMEOUT;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed and randomized fetches against a
// transaction-level model of cycle counts, strobe positions, instr and fault_code.
module tb_inst_fetch_ctrl;
    import cpu_defs_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        fetch     = 1'b0;
    logic [31:0] pc        = '0;
    logic        flush     = 1'b0;
    logic        mem_ack   = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        ir_wr;
    logic [31:0] instr;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_code;

    int          checks    = 0;
    int          failures  = 0;
    logic [31:0] exp_instr = '0;
    logic [1:0]  exp_fc    = FC_NONE;

    always #5 clk = ~clk;

    inst_fetch_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch      (fetch),
        .pc         (pc),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ir_wr      (ir_wr),
        .instr      (instr),
        .busy       (busy),
        .fault      (fault),
        .fault_code (fault_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One fetch transaction. w = extra WAIT cycles before ack (-1: never ack).
    // Cycle offset 1 is the cycle right after the accepting edge.
    task automatic run_fetch(input logic [31:0] a, input int w, input logic [31:0] d,
                             input bit do_flush);
        int exp_mreq, exp_busy, exp_ir_at, exp_fault_at;
        int n_mreq, n_busy, n_ir, n_fault, ir_at, fault_at;
        bit addr_ok;
        n_mreq = 0; n_busy = 0; n_ir = 0; n_fault = 0; ir_at = 0; fault_at = 0;
        addr_ok = 1'b1;

        if (a[1:0] != 2'b00) begin
            exp_mreq = 0; exp_busy = 1; exp_ir_at = 0; exp_fault_at = 1;
            exp_fc = FC_MISALIGN;
        end else if (do_flush) begin
            exp_mreq = w + 2; exp_busy = w + 2; exp_ir_at = 0; exp_fault_at = 0;
            exp_fc = FC_NONE;
        end else if (w >= 0 && w + 1 <= TIMEOUT - 1) begin
            exp_mreq = w + 2; exp_busy = w + 3; exp_ir_at = w + 3; exp_fault_at = 0;
            exp_fc = FC_NONE; exp_instr = d;
        end else begin
            exp_mreq = TIMEOUT; exp_busy = TIMEOUT + 1; exp_ir_at = 0;
            exp_fault_at = TIMEOUT + 1; exp_fc = FC_TIMEOUT;
        end

        @(negedge clk);
        fetch = 1'b1; pc = a; flush = 1'b0;
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        for (int off = 1; off <= exp_busy + 2; off++) begin
            @(negedge clk);
            n_mreq += int'(mem_req);
            n_busy += int'(busy);
            if (ir_wr) begin n_ir++; ir_at = off; end
            if (fault) begin n_fault++; fault_at = off; end
            if (mem_req && mem_addr !== a) addr_ok = 1'b0;
            fetch = (off <= exp_busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            pc    = $urandom;
            if (a[1:0] == 2'b00 && w >= 0 && off == w + 2) begin
                mem_ack = 1'b1; mem_rdata = d; flush = do_flush;
            end else begin
                mem_ack = (off == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_rdata = $urandom; flush = 1'b0;
            end
        end
        fetch = 1'b0; mem_ack = 1'b0; flush = 1'b0;

        check("mem_req_cycles", n_mreq, exp_mreq);
        check("busy_cycles", n_busy, exp_busy);
        check("ir_wr_count", n_ir, (exp_ir_at != 0) ? 1 : 0);
        check("ir_wr_offset", ir_at, exp_ir_at);
        check("fault_count", n_fault, (exp_fault_at != 0) ? 1 : 0);
        check("fault_offset", fault_at, exp_fault_at);
        check("mem_addr_stable", addr_ok, 1);
        check("instr", instr, exp_instr);
        check("fault_code", fault_code, exp_fc);
    endtask

    initial begin
        logic [31:0] a;
        int          w;
        bit          fl;

        #3;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_ir_wr", ir_wr, 0);
        check("rst_instr", instr, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_fault_code", fault_code, FC_NONE);
        @(negedge clk);
        rst_n = 1'b1;

        run_fetch(32'h0000_0040, 0, 32'h2001_0005, 1'b0);
        run_fetch(32'h0000_0080, 4, 32'h8C22_0004, 1'b0);
        run_fetch(32'h0000_0042, 0, 32'hDEAD_BEEF, 1'b0);
        run_fetch(32'h0000_0100, -1, 32'h0, 1'b0);
        run_fetch(32'h0000_0104, TIMEOUT - 2, 32'h1234_5678, 1'b0);
        run_fetch(32'h0000_0108, TIMEOUT - 1, 32'h0BAD_0BAD, 1'b0);
        run_fetch(32'h0000_0110, 2, 32'hFFFF_FFFF, 1'b1);
        run_fetch(32'h0000_0114, 1, 32'h0C0F_FEE0, 1'b0);

        // flush and fetch together in IDLE: the fetch is not accepted
        @(negedge clk);
        fetch = 1'b1; flush = 1'b1; pc = 32'h0000_0200;
        @(negedge clk);
        check("flush_fetch_busy", busy, 0);
        check("flush_fetch_mem_req", mem_req, 0);
        check("flush_fetch_fault_code", fault_code, exp_fc);
        fetch = 1'b0; flush = 1'b0;

        // asynchronous reset in the middle of WAIT
        @(negedge clk);
        fetch = 1'b1; pc = 32'h0000_0300;
        @(negedge clk);
        fetch = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_req", mem_req, 0);
        check("arst_busy", busy, 0);
        check("arst_instr", instr, 0);
        check("arst_ir_wr", ir_wr, 0);
        check("arst_fault", fault, 0);
        check("arst_mem_addr", mem_addr, 0);
        exp_instr = '0;
        exp_fc    = FC_NONE;
        @(negedge clk);
        rst_n = 1'b1;
        run_fetch(32'h0000_0400, 0, 32'h5555_AAAA, 1'b0);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            w  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TIMEOUT + 1));
            fl = ($urandom_range(0, 4) == 0);
            if (fl) w = int'($urandom_range(0, 8));
            run_fetch(a, w, $urandom, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Fetch-side controller for the multi-cycle CPU.
- On a fetch request from the main control FSM, issues one 32-bit word read to instruction memory over a req/ack handshake.
- Delivers the returned word with a one-cycle write strobe to the instruction register, acting as the producer end of the IR load path.
- Detects a misaligned PC and a memory timeout, and reports each as a fault.

Parameters:
- TIMEOUT, 16: max cycles waiting for mem_ack before a fault; 1..255.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch  in  1  fetch request from control FSM; sampled only in IDLE.
- pc  in  32  fetch address; captured when fetch is accepted.
- flush  in  1  abort any in-flight fetch and return to IDLE.
- mem_req  out  1  memory read request.
- mem_addr  out  32  word address presented to memory.
- mem_ack  in  1  memory has valid data on mem_rdata this cycle.
- mem_rdata  in  32  memory read data.
- ir_wr  out  1  one-cycle strobe: IR loads instr.
- instr  out  32  fetched instruction word, held until the next successful fetch.
- busy  out  1  high in every state except IDLE.
- fault  out  1  one-cycle pulse on a misaligned address or timeout.
- fault_code  out  2  00 none, 01 misaligned, 10 timeout; held until the next accepted fetch.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; mem_req=0; mem_addr=0; ir_wr=0; instr=0; busy=0; fault=0; fault_code=00; counter=0.
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - fetch=1 with pc[1:0]==00: capture pc into mem_addr, clear fault_code, go to REQ.
  - fetch=1 with pc[1:0]!=00: set fault_code=01, go to ERR.
  - fetch=0: stay in IDLE.
- REQ: mem_req=1; counter=0; go to WAIT next cycle.
- WAIT:
  - mem_req stays 1.
  - mem_ack=1: register mem_rdata into instr, drop mem_req, go to DONE.
  - mem_ack=0: counter increments. When counter reaches TIMEOUT-1 with no ack, set fault_code=10 and go to ERR.
  - If ack and timeout occur in the same cycle, ack wins.
- DONE: ir_wr=1 for exactly one cycle, then return to IDLE.
- ERR: fault=1 for exactly one cycle, instr unchanged, then return to IDLE.
- Latency:
  - Zero-wait memory (ack in the first WAIT cycle): fetch accepted at edge N, mem_req high from N+1, ir_wr high in cycle N+3.
  - Each extra wait cycle adds one cycle.
- mem_ack outside WAIT is ignored.
- mem_addr is stable for as long as mem_req=1.
- flush=1 in any state: go to IDLE next edge; mem_req, ir_wr and fault are 0 from that edge. instr and fault_code are unchanged.
  - flush overrides a same-cycle mem_ack; that data is discarded.
  - flush and fetch together in IDLE: flush wins, the fetch is not accepted.
- fetch outside IDLE is ignored, with no queuing; the control FSM must wait for busy=0.
- Reset asserted mid-fetch: immediate return to reset values; no ir_wr or fault is generated.
- All outputs are registered; no combinational path from inputs to outputs.
- Counter saturates and does not wrap.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - state encoding constants: IDLE=0, REQ=1, WAIT=2, DONE=3, ERR=4;
  - fault codes: FC_NONE, FC_MISALIGN, FC_TIMEOUT;
  - WORD_W=32.
- One sub-module, fetch_timeout_cnt: parameterised up-counter with clear, enable and a terminal-count flag.

Test Plan:
- Zero-wait fetch: pc=0x0000_0040, mem_ack in the first WAIT cycle with rdata=0x2001_0005 -> mem_addr=0x40, ir_wr pulse 3 cycles after acceptance, instr=0x2001_0005, fault_code=00.
- Wait states: ack after 5 WAIT cycles, rdata=0x8C22_0004 -> mem_req high 6 cycles, single ir_wr, instr updated, busy low after DONE.
- Misaligned: pc=0x0000_0042 -> no mem_req, fault pulse the cycle after acceptance, fault_code=01, instr keeps its prior value.
- Timeout: TIMEOUT=16, never ack -> mem_req high for 16 cycles, then fault pulse, fault_code=10, ir_wr never asserted.
- Flush: flush in the same cycle as mem_ack (rdata=0xFFFF_FFFF) -> IDLE next cycle, no ir_wr, instr unchanged; the next fetch proceeds normally.
- Async reset: drop rst_n mid-WAIT, between clock edges -> mem_req, busy and instr go to 0 immediately; after release, IDLE and fetch accepted normally.
